dmem_line_responder: RTL and testbench

- Line-granular data memory responder on the memory side of the data cache's refill and write-back interface.
- Accepts one 256-bit line read or write request at a time from the cache controller and returns a one-cycle ack after a fixed programmable latency.
- On reads, returns the full line.
- The cache holds its stall until this ack arrives; this block is the timing model of main memory behind the cache.

---
 rtl/dmem_line_responder.sv | 97 +++++++++
 tb/tb_dmem_line_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/dmem_line_responder.sv
// dmem_line_responder: fixed-latency line memory behind the data cache refill/write-back port.
// Optional out-of-range address flagging via DMEM_RANGE_CHECK_EN (adds err_o).
module dmem_line_responder #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [LINE_W-1:0] write_data_i,
    output logic [LINE_W-1:0] data_o,
    output logic              ack_o,
    output logic              busy_o
`ifdef DMEM_RANGE_CHECK_EN
    ,
    output logic              err_o
`endif
);
    localparam int IDX_W = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
    state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic wr_q, wr_d, rw_q, rw_d, oor_q, oor_d, oor_in, mem_we, unused_addr;
    logic [LINE_W-1:0] wdata_q, wdata_d, data_q, data_d;
    logic [LINE_W-1:0] mem_q [DEPTH];
`ifdef DMEM_RANGE_CHECK_EN
    assign oor_in = |(addr_i >> (5 + IDX_W));
    assign err_o  = ack_o && oor_q;
`else
    assign oor_in = 1'b0;
`endif
    assign unused_addr = ^addr_i;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        rw_d    = rw_q;
        oor_d   = oor_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: if (MemRead_i || MemWrite_i) begin
                state_d = WAIT;
                cnt_d   = 8'(LATENCY - 1);
                idx_d   = addr_i[5 +: IDX_W];
                wr_d    = MemWrite_i;
                rw_d    = MemRead_i && MemWrite_i;
                oor_d   = oor_in;
                wdata_d = write_data_i;
            end
            WAIT: if (cnt_q == 8'd0) begin
                state_d = ACK;
                mem_we  = wr_q && !oor_q;
                // plain writes leave data_o alone; read+write echoes the new line
                if (!oor_q && (rw_q || !wr_q)) data_d = wr_q ? wdata_q : mem_q[idx_q];
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            rw_q    <= 1'b0;
            oor_q   <= 1'b0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            rw_q    <= rw_d;
            oor_q   <= oor_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end
    // storage is deliberately never reset
    always_ff @(posedge clk_i) begin
        if (mem_we) mem_q[idx_q] <= wdata_q;
    end
    assign data_o = data_q;
    assign ack_o  = state_q == ACK;
    assign busy_o = state_q != IDLE;
endmodule

// File: tb/tb_dmem_line_responder.sv
// tb_dmem_line_responder: directed checks of latency, data path, reset abort and back-to-back
// handshakes; a second instance runs with LATENCY=1.
module tb_dmem_line_responder;
    logic clk = 1'b0, rst = 1'b1;
    logic [31:0] addr = '0, addr1 = '0;
    logic rd = 1'b0, wr = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
    logic [255:0] wd = '0, wd1 = '0, dout, dout1;
    logic ack, busy, ack1, busy1;
`ifdef DMEM_RANGE_CHECK_EN
    logic err, err1;
`endif
    int tests = 0, fails = 0;
    localparam logic [255:0] LA5 = {32{8'hA5}};
    localparam logic [255:0] PAT = {4{64'h0123456789ABCDEF}};
    localparam logic [255:0] L2  = {32{8'h22}};
    localparam logic [255:0] L4  = {32{8'h44}};
    localparam logic [255:0] L7  = {32{8'h77}};
    localparam logic [255:0] L5  = {32{8'h55}};
    localparam logic [255:0] L9  = {32{8'h99}};
    always #5 clk = ~clk;

    dmem_line_responder #(.LATENCY(10)) dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .MemRead_i(rd), .MemWrite_i(wr),
        .write_data_i(wd), .data_o(dout), .ack_o(ack), .busy_o(busy)
`ifdef DMEM_RANGE_CHECK_EN
        , .err_o(err)
`endif
    );
    dmem_line_responder #(.LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr1), .MemRead_i(rd1), .MemWrite_i(wr1),
        .write_data_i(wd1), .data_o(dout1), .ack_o(ack1), .busy_o(busy1)
`ifdef DMEM_RANGE_CHECK_EN
        , .err_o(err1)
`endif
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // waits on negedges for the selected instance's ack, then drops that instance's request
    task automatic wait_ack(input bit one, output int n);
        logic got;
        got = 1'b0;
        n = 0;
        while (!got && n < 50) begin
            @(negedge clk);
            n++;
            got = one ? ack1 : ack;
        end
        chk("ack_timeout", {255'd0, got}, 256'd1);
        if (one) begin rd1 = 1'b0; wr1 = 1'b0; end
        else begin rd = 1'b0; wr = 1'b0; end
    endtask

    task automatic op(input bit one, input logic [31:0] a, input logic r, input logic w,
                      input logic [255:0] d);
        int n;
        @(negedge clk);
        if (one) begin addr1 = a; rd1 = r; wr1 = w; wd1 = d; end
        else begin addr = a; rd = r; wr = w; wd = d; end
        wait_ack(one, n);
    endtask

    initial begin
        int n, acks;
        #1;
        chk("rst_ack", {255'd0, ack}, 256'd0);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_data", dout, 256'd0);
        chk("rst_busy1", {255'd0, busy1}, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        op(0, 32'h60, 0, 1, LA5);
        // read line 3: ack exactly 11 negedges after the request is raised (edge N+10)
        @(negedge clk);
        addr = 32'h60; rd = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk($sformatf("lat_ack_%0d", k), {255'd0, ack}, {255'd0, k == 11});
            chk($sformatf("lat_busy_%0d", k), {255'd0, busy}, 256'd1);
        end
        rd = 1'b0;
        chk("read_l3", dout, LA5);
        @(negedge clk);
        chk("post_ack", {255'd0, ack}, 256'd0);
        chk("post_busy", {255'd0, busy}, 256'd0);
        // write line 15, data_o unaffected by a plain write, then read back with low bits set
        op(0, 32'h1E0, 0, 1, PAT);
        chk("wr_keeps_data", dout, LA5);
        op(0, 32'h1FF, 1, 0, '0);
        chk("read_l15", dout, PAT);
        // inputs changed during WAIT are ignored
        op(0, 32'h40, 0, 1, L2);
        op(0, 32'h80, 0, 1, L4);
        @(negedge clk);
        addr = 32'h40; rd = 1'b1;
        @(negedge clk);
        addr = 32'h80; wr = 1'b1; wd = '1;
        acks = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (ack) begin acks++; rd = 1'b0; wr = 1'b0; end
        end
        chk("midflight_acks", 256'(acks), 256'd1);
        chk("midflight_data", dout, L2);
        op(0, 32'h80, 1, 0, '0);
        chk("line4_intact", dout, L4);
        // reset in the middle of a write to line 7
        op(0, 32'hE0, 0, 1, L7);
        @(negedge clk);
        addr = 32'hE0; wr = 1'b1; wd = '1;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", {255'd0, busy}, 256'd1);
        rst = 1'b1;
        wr = 1'b0;
        #1;
        chk("rst_mid_busy", {255'd0, busy}, 256'd0);
        chk("rst_mid_ack", {255'd0, ack}, 256'd0);
        chk("rst_mid_data", dout, 256'd0);
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("rst_no_ack", 256'(acks), 256'd0);
        op(0, 32'hE0, 1, 0, '0);
        chk("line7_kept", dout, L7);
        // LATENCY=1, request held: ack every third cycle
        op(1, 32'hA0, 0, 1, L5);
        @(negedge clk);
        addr1 = 32'hA0; rd1 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_ack_%0d", k), {255'd0, ack1}, {255'd0, (k % 3) == 2});
        end
        rd1 = 1'b0;
        chk("b2b_data", dout1, L5);
        op(1, 32'h120, 1, 1, L9);
        chk("rw_echo", dout1, L9);
        op(1, 32'hA0, 1, 0, '0);
        chk("reread_l5", dout1, L5);
        op(1, 32'h120, 1, 0, '0);
        chk("read_l9", dout1, L9);
`ifdef DMEM_RANGE_CHECK_EN
        op(0, 32'h0, 0, 1, L2);
        chk("inrange_err", {255'd0, err}, 256'd0);
        @(negedge clk);
        addr = 32'h4000; wr = 1'b1; wd = '1;
        wait_ack(0, n);
        chk("oor_err", {255'd0, err}, 256'd1);
        @(negedge clk);
        chk("oor_err_drop", {255'd0, err}, 256'd0);
        op(0, 32'h0, 1, 0, '0);
        chk("line0_kept", dout, L2);
        chk("inrange_rd_err", {255'd0, err}, 256'd0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
